gen_linear_part_pipe: RTL and testbench
=======================================

# gen_linear_part_pipe

Registered linear-recombination stage directly downstream of `gen_nonlinear_part` in the decomposed 8-bit CLA adder. Accepts operands `a`, `b` with the 501-bit nonlinear product vector `n`, XOR-reduces each product group into a carry, forms the sum with the linear (XOR) terms, and returns an 8-bit result. It is a 2-stage valid/ready pipeline with backpressure, a synchronous flush, and a wrapping result counter.

## Interface
- `CNT_W`, default 16: width of the completed-result counter.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clr`  in  1: synchronous flush. Clears pipeline valids and the counter.
- `in_valid`  in  1: `a`, `b`, `n` valid.
- `in_ready`  out  1: stage accepts input this cycle.
- `a`  in  8: adder operand A.
- `b`  in  8: adder operand B.
- `n`  in  501: nonlinear products from `gen_nonlinear_part`. Carry-in is 0.
- `out_valid`  out  1: `s` valid.
- `out_ready`  in  1: consumer accepts `s`.
- `s`  out  8: sum (a+b) mod 256.
- `result_cnt`  out  CNT_W: number of completed output handshakes, modulo 2^CNT_W.

## Operation
- Group ranges in `n`:
  - g0=n[2:0]
  - g1=n[9:3]
  - g2=n[24:10]
  - g3=n[55:25]
  - g4=n[118:56]
  - g5=n[245:119]
  - g6=n[500:246]
- Group i has width 2^(i+2)-1.
- Carries: c0=0 and c(i+1)=^g_i for i=0..6. No carry-out of bit 7 exists; the result is 8 bits and overflow is discarded.
- Stage 1 register on input handshake: p=a^b (8 bits), c[7:1] (7 bits), v1.
- Stage 2 register when stage 1 advances: s=p^{c[7:1],1'b0}, v2.
- `n` is trusted. No consistency check against `a`/`b`; a corrupted `n` propagates into `s`.
- Stage 2 advances when `!v2 | out_ready`. Stage 1 advances when `!v1 | stage2_advances`.
- `in_ready` = stage-1 advance condition. It is combinational from `out_ready` through both stages; there is no skid buffer.
- `result_cnt` increments on `out_valid & out_ready` and wraps to 0 after 2^CNT_W-1.
- `clr` has priority over every handshake:
  - v1 and v2 go to 0.
  - `result_cnt` goes to 0, and a handshake in the same cycle is not counted.
  - `in_ready` is still driven normally that cycle, but any accepted input is dropped.
- Data registers are not cleared by `clr` or reset. They only matter when their valid is set.

## Timing
- Reset values:
  - `out_valid`=0
  - `result_cnt`=0
  - `s`=0
  - `in_ready`=1, since both stages are empty
  - internal v1=v2=0
- Latency: an input accepted at edge k gives `out_valid`=1 with the correct `s` after edge k+1, when no stall occurs.
- Throughput: 1 result per cycle with `out_ready` held high.
- Stall: while `out_valid & !out_ready`, `s` and `out_valid` hold stable. Stage 1 stays full; `in_ready` drops once stage 1 is also full.
- Pipeline full with `out_ready`=1: input is accepted in the same cycle.
- Reset asserted mid-stream: all valids drop immediately (asynchronous) and the in-flight results are lost.

## Structure
- Shared package `cla_pkg`:
  - `ADDER_W`=8
  - `NL_W`=501
  - `group_lo(i)` / `group_hi(i)` constants or functions; the same table is used by `gen_nonlinear_part` benches.
- One sub-module, `cla_carry_reduce`: combinational; `n[500:0]` in, `c[7:1]` out.
- The top handles the pipeline registers, handshake and counter.

## Test plan
- Bench drives `n` from a `gen_nonlinear_part` instance.
- Reset, then a=8'h5A, b=8'h3C with `out_ready`=1 → `s`=8'h96 two edges after acceptance; `result_cnt`=1.
- a=8'hFF, b=8'h01 → `s`=8'h00 (carry ripples through all 7 groups, overflow dropped). a=8'h7F, b=8'h01 → `s`=8'h80.
- `n`=0 forced, a=8'h0F, b=8'h01 → `s`=8'h0E (no carries; shows `n` is trusted).
- Back-to-back stream of 256 pairs (a=i, b=255-i) with `out_ready` low for cycles 3–6:
  - all `s`=8'hFF, in order
  - `in_ready` low while both stages are full
  - no loss or duplicate
  - `result_cnt`=256 at the end
- `clr` asserted with `out_valid & out_ready` and a new `in_valid` in the same cycle → next cycle `out_valid`=0, `result_cnt`=0, and the dropped input never appears.
- CNT_W=4: 17 results → `result_cnt`=1. `rst_n` pulsed mid-stream → `out_valid`=0 immediately and `in_ready`=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and group-range table for the decomposed 8-bit CLA adder.
package cla_pkg;

  localparam int ADDER_W    = 8;
  localparam int NL_W       = 501;
  localparam int NUM_GROUPS = 7;

  // Group i holds 2^(i+2)-1 product terms; groups are packed from bit 0 upward.
  function automatic int group_lo(input int i);
    return (1 << (i + 2)) - 4 - i;
  endfunction

  function automatic int group_hi(input int i);
    return (1 << (i + 3)) - 6 - i;
  endfunction

endpackage

// File: rtl/cla_carry_reduce.sv
// Combinational carry recovery: each product group XOR-reduces to the carry
// into the next bit position. Carry-in is zero, so bit 0 has no carry.
module cla_carry_reduce
  import cla_pkg::*;
(
  input  logic [NL_W-1:0]    n,
  output logic [ADDER_W-1:1] c
);

  // One XOR reduction per group; group i produces the carry into bit i+1.
  for (genvar i = 0; i < NUM_GROUPS; i++) begin : g_grp
    localparam int LO = group_lo(i);
    localparam int HI = group_hi(i);
    assign c[i+1] = ^n[HI:LO];
  end

endmodule

// File: rtl/gen_linear_part_pipe.sv
// Two-stage registered linear recombination of the decomposed CLA adder.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid and data stable until that edge; ready may
// depend combinationally on the downstream ready (in_ready follows out_ready
// through both stages, there is no skid buffer).
module gen_linear_part_pipe
  import cla_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDER_W-1:0]  a,
  input  logic [ADDER_W-1:0]  b,
  input  logic [NL_W-1:0]     n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDER_W-1:0]  s,
  output logic [CNT_W-1:0]    result_cnt
);

  logic                v1;
  logic                v2;
  logic                adv1;
  logic                adv2;
  logic [ADDER_W-1:0]  p_q;
  logic [ADDER_W-1:1]  c_q;
  logic [ADDER_W-1:1]  c_d;

  // n is trusted as-is; a corrupted n simply yields a wrong sum.
  cla_carry_reduce u_carry (
    .n (n),
    .c (c_d)
  );

  // A stage moves when it is empty or its successor is moving.
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Valid bits: cleared by reset and flush, otherwise shift with the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (clr) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
    end
  end

  // Stage 1 data: propagate terms and recovered carries, captured on accept.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      p_q <= a ^ b;
      c_q <= c_d;
    end
  end

  // Stage 2 data: the sum, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else if (adv2 && v1) begin
      s <= p_q ^ {c_q, 1'b0};
    end
  end

  // Completed-handshake counter; wraps naturally, flush wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (clr) begin
      result_cnt <= '0;
    end else if (v2 && out_ready) begin
      result_cnt <= result_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gen_linear_part_pipe.sv
// Self-checking bench for gen_linear_part_pipe: directed steps with random
// product vectors, checked against an arithmetic reference model.
module tb_gen_linear_part_pipe;
  import cla_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (CNT_W = 16)
  logic         rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]   a, b, s;
  logic [500:0] n;
  logic [15:0]  result_cnt;

  // second instance (CNT_W = 4)
  logic         rst2_n, clr2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]   a2, b2, s2;
  logic [500:0] n2;
  logic [3:0]   result_cnt2;

  gen_linear_part_pipe #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .n(n), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .result_cnt(result_cnt)
  );

  gen_linear_part_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst2_n), .clr(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .n(n2), .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .result_cnt(result_cnt2)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [7:0]  exp_q[$];
  int          edge_q[$];
  logic [15:0] exp_cnt = '0;
  logic [7:0]  cur_exp;
  bit          saw_stall_ready_low = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Product vector whose group parities equal the true ripple carries of x+y;
  // the remaining bits are random so every term position gets exercised.
  function automatic logic [500:0] gen_n(input logic [7:0] x, input logic [7:0] y);
    logic [500:0] r;
    int           mask, ci;
    bit           par;
    for (int k = 0; k < NL_W; k++) r[k] = 1'($urandom_range(0, 1));
    for (int g = 0; g < NUM_GROUPS; g++) begin
      mask = (1 << (g + 1)) - 1;
      ci   = ((int'(x) & mask) + (int'(y) & mask)) >> (g + 1);
      par  = 1'b0;
      for (int k = group_lo(g); k <= group_hi(g); k++) par ^= r[k];
      if (par != ci[0]) r[group_lo(g)] = ~r[group_lo(g)];
    end
    return r;
  endfunction

  // ---------------- driver / monitor ----------------
  // One clock cycle: check ports at the negedge, update the model, step the
  // clock and check the counter just after the edge.
  task automatic tick(output bit acc);
    bit hs;
    @(negedge clk);
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
    chk("out_valid", out_valid,
        (exp_q.size() >= 2) || (exp_q.size() == 1 && cyc > edge_q[0]));
    if (in_valid && !in_ready && exp_q.size() == 2) saw_stall_ready_low = 1;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        chk("s_data", s, exp_q.pop_front());
        void'(edge_q.pop_front());
      end
    end
    if (clr) begin
      exp_q.delete();
      edge_q.delete();
      exp_cnt = '0;
    end else begin
      if (acc) begin
        exp_q.push_back(cur_exp);
        edge_q.push_back(cyc + 1);
      end
      if (hs) exp_cnt = exp_cnt + 16'd1;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("result_cnt", result_cnt, exp_cnt);
  endtask

  task automatic one_shot(input logic [7:0] x, input logic [7:0] y, input bit zero_n,
                          input logic [7:0] exp_s, input string tag);
    bit acc;
    a = x; b = y;
    n = zero_n ? '0 : gen_n(x, y);
    cur_exp = zero_n ? (x ^ y) : (x + y);
    in_valid = 1'b1; out_ready = 1'b1;
    tick(acc);
    chk({tag, "_acc"}, acc, 1);
    in_valid = 1'b0;
    tick(acc);
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_s"}, s, exp_s);
    tick(acc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit acc;
    int sc, waited;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; n = '0; cur_exp = '0;
    rst2_n = 1'b0; clr2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    a2 = '0; b2 = '0; n2 = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result_cnt", result_cnt, 0);
    chk("rst_s", s, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;

    // basic sums, latency and counter
    one_shot(8'h5A, 8'h3C, 0, 8'h96, "sum_5a_3c");
    chk("cnt_after_first", result_cnt, 1);
    one_shot(8'hFF, 8'h01, 0, 8'h00, "sum_ff_01");
    one_shot(8'h7F, 8'h01, 0, 8'h80, "sum_7f_01");
    one_shot(8'h0F, 8'h01, 1, 8'h0E, "trusted_n0");
    for (int r = 0; r < 4; r++) begin
      logic [7:0] x, y;
      x = 8'($urandom); y = 8'($urandom);
      one_shot(x, y, 0, x + y, "sum_rand");
    end

    // flush counter, then a 256-pair stream with a consumer stall
    clr = 1'b1; tick(acc); clr = 1'b0;
    sc = 0;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i); b = 8'(255 - i); n = gen_n(a, b); cur_exp = a + b;
      in_valid = 1'b1;
      waited = 0;
      acc = 0;
      while (!acc && waited < 20) begin
        out_ready = !(sc >= 3 && sc <= 6);
        tick(acc);
        sc++; waited++;
      end
      if (!acc) chk("stream_accept_timeout", waited, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      tick(acc);
      waited++;
    end
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_cnt", result_cnt, 256);
    chk("stream_saw_in_ready_low", saw_stall_ready_low, 1);

    // flush together with an output handshake and a new input
    a = 8'h01; b = 8'h02; n = gen_n(a, b); cur_exp = 8'h03; in_valid = 1'b1;
    tick(acc);
    a = 8'h03; b = 8'h04; n = gen_n(a, b); cur_exp = 8'h07;
    tick(acc);
    a = 8'h09; b = 8'h09; n = gen_n(a, b); cur_exp = 8'h12;
    chk("clr_pre_ov", out_valid, 1);
    clr = 1'b1;
    tick(acc);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_ov", out_valid, 0);
    chk("clr_cnt", result_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      chk("clr_no_ghost", out_valid, 0);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    // narrow counter wrap, then asynchronous reset mid-stream
    a2 = 8'h11; b2 = 8'h22; n2 = gen_n(a2, b2);
    in_valid2 = 1'b1;
    repeat (17) @(posedge clk);
    #1 in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("w4_cnt_wrap", result_cnt2, 1);
    chk("w4_s", s2, 8'h33);
    in_valid2 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("w4_pre_rst_ov", out_valid2, 1);
    rst2_n = 1'b0;
    #1;
    chk("w4_rst_ov", out_valid2, 0);
    chk("w4_rst_in_ready", in_ready2, 1);
    chk("w4_rst_cnt", result_cnt2, 0);
    in_valid2 = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    chk("w4_post_rst_ov", out_valid2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
